// File: rtl/led_fade_pkg.sv
// Shared defaults and helpers for the LED afterglow PWM stage.
// Optional feature macro: LED_FADE_GAMMA_EN (perceptual duty in each channel).
package led_fade_pkg;

    localparam int PWM_W_DEF      = 8;
    localparam int MAX_LEVEL_DEF  = (1 << PWM_W_DEF) - 1;
    localparam int DECAY_DIV_DEF  = 256;
    localparam int DECAY_STEP_DEF = 16;

    // Saturating subtraction: a level at or below the step lands on 0, never wraps.
    function automatic logic [31:0] sat_sub(input logic [31:0] level, input logic [31:0] step);
        logic [31:0] res;
        if (level > step) begin
            res = level - step;
        end else begin
            res = 32'd0;
        end
        return res;
    endfunction

endpackage

// File: rtl/led_fade_pwm_channel.sv
// One LED channel: brightness level register, set/decay priority logic and
// registered PWM compare. With LED_FADE_GAMMA_EN defined the compare uses
// (level*level)>>PWM_W; otherwise the level is compared directly.
module led_fade_channel
    import led_fade_pkg::*;
#(
    parameter int PWM_W      = PWM_W_DEF,
    parameter int MAX_LEVEL  = (1 << PWM_W) - 1,
    parameter int DECAY_STEP = DECAY_STEP_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_set,
    input  logic             i_tick,
    input  logic [PWM_W-1:0] i_pwm_cnt,
    output logic             o_led
);

    logic [PWM_W-1:0] r_level;
    logic [PWM_W-1:0] w_next_level;
    logic [PWM_W-1:0] w_duty;
    logic             r_led;

`ifdef LED_FADE_GAMMA_EN
    localparam int SQ_W = 2 * PWM_W;
    logic [SQ_W-1:0] w_sq;
    assign w_sq   = SQ_W'(r_level) * SQ_W'(r_level);
    assign w_duty = PWM_W'(w_sq >> PWM_W);
`else
    assign w_duty = r_level;
`endif

    // Next brightness: disable clears, a set beats a decay tick, ticks decay saturating.
    always_comb begin
        w_next_level = r_level;
        if (!i_en) begin
            w_next_level = {PWM_W{1'b0}};
        end else if (i_set) begin
            w_next_level = PWM_W'(MAX_LEVEL);
        end else if (i_tick) begin
            w_next_level = PWM_W'(sat_sub(32'(r_level), 32'(DECAY_STEP)));
        end else begin
            w_next_level = r_level;
        end
    end

    // Brightness level register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_level <= {PWM_W{1'b0}};
        end else begin
            r_level <= w_next_level;
        end
    end

    // Registered PWM compare; full level is forced solidly on.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_led <= 1'b0;
        end else begin
            r_led <= i_en & ((r_level == PWM_W'(MAX_LEVEL)) | (w_duty > i_pwm_cnt));
        end
    end

    assign o_led = r_led;

endmodule

// File: rtl/led_fade_pwm.sv
// LED chaser output stage: turns each pattern bit into a PWM LED with a
// decaying afterglow. Owns the input register, PWM counter, decay prescaler
// and tick output. Optional macro LED_FADE_GAMMA_EN selects perceptual duty.
module led_fade_pwm
    import led_fade_pkg::*;
#(
    parameter int CH         = 4,
    parameter int PWM_W      = PWM_W_DEF,
    parameter int MAX_LEVEL  = (1 << PWM_W) - 1,
    parameter int DECAY_DIV  = DECAY_DIV_DEF,
    parameter int DECAY_STEP = DECAY_STEP_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [CH-1:0] led_in,
    output logic [CH-1:0] led_out,
    output logic          tick_o
);

    localparam int PRE_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

    logic [CH-1:0]    r_led_in_q;
    logic [PWM_W-1:0] r_pwm_cnt;
    logic [PRE_W-1:0] r_prescaler;
    logic             r_tick;
    logic             w_decay_tick;
    logic [CH-1:0]    w_led;

    // Gated with en so no tick is reported while the block is disabled.
    assign w_decay_tick = en & (r_prescaler == PRE_W'(DECAY_DIV - 1));

    // Sample the on-chip pattern once per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led_in_q <= {CH{1'b0}};
        end else begin
            r_led_in_q <= led_in;
        end
    end

    // Free-running PWM counter, wraps naturally, parked at 0 while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_cnt <= {PWM_W{1'b0}};
        end else if (!en) begin
            r_pwm_cnt <= {PWM_W{1'b0}};
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
        end
    end

    // Decay prescaler 0..DECAY_DIV-1, parked at 0 while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prescaler <= {PRE_W{1'b0}};
        end else if (!en) begin
            r_prescaler <= {PRE_W{1'b0}};
        end else if (w_decay_tick) begin
            r_prescaler <= {PRE_W{1'b0}};
        end else begin
            r_prescaler <= r_prescaler + PRE_W'(1);
        end
    end

    // Registered copy of the decay tick for debug and bench sync.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_decay_tick;
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        led_fade_channel #(
            .PWM_W      (PWM_W),
            .MAX_LEVEL  (MAX_LEVEL),
            .DECAY_STEP (DECAY_STEP)
        ) u_ch (
            .i_clk     (clk),
            .i_rst_n   (rst_n),
            .i_en      (en),
            .i_set     (r_led_in_q[g]),
            .i_tick    (w_decay_tick),
            .i_pwm_cnt (r_pwm_cnt),
            .o_led     (w_led[g])
        );
    end

    assign led_out = w_led;
    assign tick_o  = r_tick;

endmodule

// File: tb/tb_led_fade_pwm.sv
// Self-checking bench for led_fade_pwm (PWM_W=4, DECAY_DIV=4, DECAY_STEP=5).
// Reference model tracks brightness per channel and the cycle count since
// enable; PWM phase and tick position follow from modular arithmetic.
module tb_led_fade_pwm;

    localparam int MAXL = 15;
    localparam int DIV  = 4;
    localparam int STEP = 5;
    localparam int PER  = 16;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] led_in;
    logic [3:0] led_out;
    logic       tick_o;

    int n_cmp;
    int n_err;

    // model state
    int         m_level [4];
    logic [3:0] m_q;
    logic [3:0] m_led;
    logic       m_tick;
    int         m_n;

    led_fade_pwm #(
        .CH         (4),
        .PWM_W      (4),
        .MAX_LEVEL  (MAXL),
        .DECAY_DIV  (DIV),
        .DECAY_STEP (STEP)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .led_in  (led_in),
        .led_out (led_out),
        .tick_o  (tick_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int duty_of(input int lvl);
`ifdef LED_FADE_GAMMA_EN
        return (lvl * lvl) / PER;
`else
        return lvl;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_level[i] = 0;
        m_q    = 4'b0000;
        m_led  = 4'b0000;
        m_tick = 1'b0;
        m_n    = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        int         phase;
        logic       tk;
        logic [3:0] nled;
        phase = m_n % PER;
        tk    = en && ((m_n % DIV) == DIV - 1);
        for (int i = 0; i < 4; i++) begin
            nled[i] = en && ((m_level[i] == MAXL) || (duty_of(m_level[i]) > phase));
        end
        for (int i = 0; i < 4; i++) begin
            if (!en)            m_level[i] = 0;
            else if (m_q[i])    m_level[i] = MAXL;
            else if (tk)        m_level[i] = (m_level[i] > STEP) ? m_level[i] - STEP : 0;
        end
        m_led  = nled;
        m_q    = led_in;
        m_tick = tk;
        m_n    = en ? m_n + 1 : 0;
    endtask

    task automatic step(input logic e, input logic [3:0] li);
        en     = e;
        led_in = li;
        @(posedge clk);
        model_edge();
        #1;
        check("led_out", 32'(led_out), 32'(m_led));
        check("tick_o", 32'(tick_o), 32'(m_tick));
    endtask

    initial begin
        int guard;
        int ticks;
        n_cmp  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        en     = 1'b0;
        led_in = 4'b0000;
        model_reset();

        // reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_led_out", 32'(led_out), 32'd0);
        check("rst_tick_o", 32'(tick_o), 32'd0);
        rst_n = 1'b1;

        // idle with en: LEDs dark, tick every DIV cycles
        ticks = 0;
        for (int c = 0; c < 64; c++) begin
            step(1'b1, 4'b0000);
            if (tick_o === 1'b1) ticks++;
        end
        check("idle_tick_count", 32'(ticks), 32'(64 / DIV));

        // channel 0 held on
        for (int c = 0; c < 20; c++) step(1'b1, 4'b0001);
        check("hold_on_led", 32'(led_out), 32'h1);

        // release and fade out
        for (int c = 0; c < 60; c++) step(1'b1, 4'b0000);
        check("fade_done_led", 32'(led_out), 32'h0);

        // set coinciding with a decay tick on channel 1
        for (int c = 0; c < 3; c++) step(1'b1, 4'b0010);
        guard = 0;
        while (((m_n % DIV) != 2) && guard < 8) begin
            step(1'b1, 4'b0000);
            guard++;
        end
        step(1'b1, 4'b0010);
        step(1'b1, 4'b0000);
        step(1'b1, 4'b0000);
        check("set_beats_tick", 32'(led_out[1]), 32'd1);
        for (int c = 0; c < 40; c++) step(1'b1, 4'b0000);

        // fade to 10, disable for 3 cycles, re-enable
        for (int c = 0; c < 3; c++) step(1'b1, 4'b0001);
        guard = 0;
        while ((m_level[0] != 10) && guard < 12) begin
            step(1'b1, 4'b0000);
            guard++;
        end
        check("reach_level10", 32'(m_level[0]), 32'd10);
        step(1'b0, 4'b0000);
        check("en_low_led", 32'(led_out), 32'h0);
        step(1'b0, 4'b0000);
        step(1'b0, 4'b0000);
        for (int c = 0; c < 16; c++) step(1'b1, 4'b0000);
        check("after_en_dark", 32'(led_out), 32'h0);

        // randomized patterns with occasional disable
        for (int c = 0; c < 400; c++) begin
            step(($urandom_range(0, 15) != 0), 4'($urandom_range(0, 15)));
        end

        // async reset while channel 0 is lit
        for (int c = 0; c < 4; c++) step(1'b1, 4'b0001);
        check("pre_rst_lit", 32'(led_out[0]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_led", 32'(led_out), 32'h0);
        check("async_rst_tick", 32'(tick_o), 32'd0);
        model_reset();
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 24; c++) step(1'b1, 4'b0000);
        for (int c = 0; c < 40; c++) step(1'b1, 4'($urandom_range(0, 15)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/led_fade_pwm.md
Name: led_fade_pwm

Overview:
- Downstream output stage for the 4-bit one-hot LED chaser pattern.
- Converts each pattern bit into a PWM-driven LED with afterglow.
- A bit that is high drives its LED at full brightness.
- When the bit drops, brightness decays in saturating steps, so the chaser shows a fading tail.
- Sits between the pattern generator and the board LED pins.

Parameters:
- CH, 4, number of LED channels.
- PWM_W, 8, width of PWM counter and brightness level.
- MAX_LEVEL, 2^PWM_W-1 (255), level loaded while a pattern bit is high; this level means fully on.
- DECAY_DIV, 256, clk cycles between decay ticks; must be >= 1.
- DECAY_STEP, 16, amount subtracted from each idle channel per decay tick.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  block enable; low forces all LEDs off and clears state.
- led_in  input  CH  pattern from the chaser; no one-hot requirement, any bit mix is legal.
- led_out  output  CH  registered PWM drive to the LED pins; 1 = lit.
- tick_o  output  1  registered one-cycle pulse on each decay tick, for debug and bench sync.

Behaviour:
- Single clock domain: clk. Reset is asynchronous, active-low (rst_n).
- Reset values (rst_n low): led_in_q, all levels, pwm_cnt, prescaler, led_out and tick_o all 0.
- Input register: led_in is sampled into led_in_q every cycle. It is not synchronised; the source is on-chip and synchronous.
- pwm_cnt is free-running, PWM_W bits, 0..MAX_LEVEL. It wraps to 0 with no idle cycle.
- Prescaler counts 0..DECAY_DIV-1 and wraps. decay_tick is asserted combinationally when prescaler == DECAY_DIV-1. tick_o registers decay_tick.
- Per-channel level update, priority order:
  1. en low: level <= 0.
  2. led_in_q[i] high: level <= MAX_LEVEL. A set always wins over a simultaneous decay tick.
  3. decay_tick and level > DECAY_STEP: level <= level - DECAY_STEP.
  4. decay_tick and level <= DECAY_STEP: level <= 0. The level saturates at 0 and never wraps.
  5. Otherwise: hold.
- Output compare (registered):
  - led_out[i] <= en & ((level == MAX_LEVEL) | (level > pwm_cnt)).
  - Level 0: always off.
  - Level MAX_LEVEL: always on.
  - Level L (0 < L < MAX_LEVEL): on for L of every 2^PWM_W cycles.
- Latency: led_in rising, sampled at edge t -> level = MAX at edge t+1 -> led_out = 1 from edge t+2.
- While en is low:
  - pwm_cnt and prescaler are held at 0.
  - led_out is 0 and tick_o is 0 from the next edge.
  - On en rising, counting restarts from 0. The first tick occurs DECAY_DIV cycles later.
- Reset asserted mid-fade clears all state immediately (asynchronous). No glow survives reset.
- DECAY_STEP >= MAX_LEVEL: a channel goes dark on the first tick after its bit falls.

Optional Feature:
- Macro: LED_FADE_GAMMA_EN.
- Defined: compare uses the perceptual value g = (level*level) >> PWM_W, computed with a 2*PWM_W-bit product. The level == MAX_LEVEL full-on override is retained. The fade tail looks linear to the eye.
- Undefined: compare uses level directly (linear duty). No multiplier is synthesised.

Decomposition:
- Package led_fade_pkg holds:
  - localparams for default PWM_W, MAX_LEVEL, DECAY_DIV and DECAY_STEP;
  - a function sat_sub(level, step) returning the saturating subtraction.
- One natural sub-module, led_fade_channel, instantiated CH times. It contains one level register, the update priority logic and the output compare/register.
- The top level owns the input register, pwm_cnt, prescaler and tick_o.

Test Plan (overrides: PWM_W=4, MAX_LEVEL=15, DECAY_DIV=4, DECAY_STEP=5):
- Reset then en=1, led_in=0 for 64 cycles -> led_out stays 0000; tick_o pulses every 4 cycles.
- led_in=0001 held -> led_out[0]=1 continuously from 2 edges after sampling; other bits stay 0.
- led_in 0001 then 0000 -> level[0] steps 15 -> 10 -> 5 -> 0 on successive ticks. Duty over each 16-cycle window is 10/16, then 5/16, then 0/16.
- led_in bit set in the same cycle as decay_tick -> level becomes 15, not 10.
- Start a fade at level 10, deassert en for 3 cycles, reassert -> led_out = 0000 within 1 edge; level is 0 after en returns; the first tick_o arrives 4 cycles after en rises.
- Assert rst_n low asynchronously mid-PWM-high -> led_out drops to 0 without waiting for a clk edge. With LED_FADE_GAMMA_EN, level 10 gives (100>>4)=6/16 duty.
